// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: FSM encoding and register map.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Byte offsets of the four word registers inside the block.
    localparam logic [3:0] OFF_PEND  = 4'h0;
    localparam logic [3:0] OFF_MASK  = 4'h4;
    localparam logic [3:0] OFF_CTRL  = 4'h8;
    localparam logic [3:0] OFF_CAUSE = 4'hC;

    localparam int CAUSE_VALID_BIT = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of the lowest one.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic         o_any,
    output logic [2:0]   o_idx
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_any = 1'b0;
        o_idx = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_any = 1'b1;
                o_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter feeding the core's single IRQ line, with a
// memory-mapped PEND/MASK/CTRL/CAUSE register block and kernel-mode nesting guard.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int          NSRC      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic            kernel_mode,
    input  logic            irq_ack,
    output logic            irq_out,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic            mem_wr,
    input  logic            mem_rd,
    output logic [31:0]     rdata
);

    irq_state_e      r_state;
    irq_state_e      w_nextState;
    logic [NSRC-1:0] r_srcPrev;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic            r_gie;
    logic            r_causeValid;
    logic [2:0]      r_causeIdx;
    logic            r_seenKernel;
    logic            r_irqOut;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_ackClr;
    logic            w_eligAny;
    logic [2:0]      w_sel;
    logic            w_hit;
    logic            w_wrEn;
    logic [1:0]      w_regSel;
    logic            w_take;
    logic            w_return;
    logic            w_unused;

    assign w_hit    = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_regSel = addr[3:2];
    assign w_wrEn   = mem_wr && w_hit;
    assign w_unused = ^{addr[1:0], wdata};

    assign w_rise = src_irq & ~r_srcPrev;
    assign w_elig = r_pend & r_mask;
    assign w_w1c  = (w_wrEn && (w_regSel == OFF_PEND[3:2])) ? wdata[NSRC-1:0] : '0;

    irq_prio_enc #(
        .N(NSRC)
    ) u_prioEnc (
        .i_req(w_elig),
        .o_any(w_eligAny),
        .o_idx(w_sel)
    );

    always_comb begin
        w_ackClr = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_ackClr[i] = w_take && w_eligAny && (w_sel == 3'(i));
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_take      = 1'b0;
        w_return    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_gie && w_eligAny && !kernel_mode) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    w_nextState = SERVICE;
                    w_take      = 1'b1;
                end else if (!w_eligAny || !r_gie) begin
                    w_nextState = IDLE;
                end
            end
            SERVICE: begin
                // Handler return: back in user mode after having been in kernel mode.
                if (!kernel_mode && r_seenKernel) begin
                    w_nextState = IDLE;
                    w_return    = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_irqOut <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_irqOut <= (w_nextState == REQ);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seenKernel <= 1'b0;
        end else if (r_state == SERVICE && !w_return) begin
            r_seenKernel <= r_seenKernel | kernel_mode;
        end else begin
            r_seenKernel <= 1'b0;
        end
    end

    // A new rise wins over a same-cycle clear so no event is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_srcPrev <= '0;
            r_pend    <= '0;
        end else begin
            r_srcPrev <= src_irq;
            r_pend    <= (r_pend & ~(w_w1c | w_ackClr)) | w_rise;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
            r_gie  <= 1'b0;
        end else if (w_wrEn) begin
            if (w_regSel == OFF_MASK[3:2]) begin
                r_mask <= wdata[NSRC-1:0];
            end
            if (w_regSel == OFF_CTRL[3:2]) begin
                r_gie <= wdata[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_causeValid <= 1'b0;
            r_causeIdx   <= 3'd0;
        end else if (w_take) begin
            r_causeValid <= 1'b1;
            r_causeIdx   <= w_sel;
        end else if (w_return) begin
            r_causeValid <= 1'b0;
        end
    end

    assign irq_out = r_irqOut;

    always_comb begin
        rdata = '0;
        if (mem_rd && w_hit) begin
            case (w_regSel)
                OFF_PEND[3:2]: rdata[NSRC-1:0] = r_pend;
                OFF_MASK[3:2]: rdata[NSRC-1:0] = r_mask;
                OFF_CTRL[3:2]: rdata[0]        = r_gie;
                default: begin
                    rdata[CAUSE_VALID_BIT] = r_causeValid;
                    rdata[2:0]             = r_causeIdx;
                end
            endcase
        end
    end

endmodule
